// File: rtl/count_display_pkg.sv
// Shared constants and the hex-to-segment decode for the count display.
package count_display_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/count_sync_filter.sv
// Two-flop synchroniser on the ripple-counter bits followed by a stability
// filter that emits a one-cycle accept once the value has held long enough.
module count_sync_filter
   import count_display_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] count_i,
   output logic [3:0] value_o,
   output logic       accept_o
);

   localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

   logic [3:0] meta_q, sync_q, prev_q, value_q;
   logic [3:0] cnt_q, cnt_d;
   logic       accept_q, accept_d;
   logic       changed;

   // Run-length of identical synchronised samples, saturating at the threshold.
   always_comb begin
      changed  = (sync_q != prev_q);
      cnt_d    = changed ? 4'd1 : ((cnt_q == StableMax) ? StableMax : cnt_q + 4'd1);
      // Fire only on the cycle the threshold is first reached by this run.
      accept_d = (cnt_d == StableMax) && (changed || (cnt_q != StableMax));
   end

   // Synchroniser, filter state and registered accept/value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q   <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         accept_q <= 1'b0;
         value_q  <= '0;
      end else begin
         meta_q   <= count_i;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
         if (accept_d) value_q <= sync_q;
      end
   end

   assign value_o  = value_q;
   assign accept_o = accept_q;

endmodule

// File: rtl/count_display_driver.sv
// Filters the ripple-counter value, keeps a four-deep history of distinct
// settled values and scans them onto a multiplexed active-low 7-seg display.
module count_display_driver
   import count_display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic [3:0] count_in,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       new_value
);

   localparam logic [19:0] RefreshLast = 20'(REFRESH_DIV - 1);

   logic [3:0] flt_value;
   logic       flt_accept;

   logic [NUM_DIGITS-1:0][3:0] hist_q, hist_d;
   logic [NUM_DIGITS-1:0]      valid_q, valid_d;
   logic [19:0]                refresh_q, refresh_d;
   logic [1:0]                 idx_q, idx_d;
   logic [6:0]                 seg_q, seg_d;
   logic                       dp_q, dp_d;
   logic [3:0]                 an_q, an_d;
   logic                       new_value_q, push;
   logic                       wrap;

   count_sync_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk_i    (clock_in),
      .rst_ni   (reset),
      .count_i  (count_in),
      .value_o  (flt_value),
      .accept_o (flt_accept)
   );

   // History push, scan advance and next display contents.
   always_comb begin
      hist_d  = hist_q;
      valid_d = valid_q;
      push    = 1'b0;
      if (flt_accept && (!valid_q[0] || (flt_value != hist_q[0]))) begin
         push    = 1'b1;
         hist_d  = {hist_q[NUM_DIGITS-2:0], flt_value};
         valid_d = {valid_q[NUM_DIGITS-2:0], 1'b1};
      end

      wrap      = (refresh_q == RefreshLast);
      refresh_d = wrap ? '0 : refresh_q + 20'd1;
      idx_d     = wrap ? idx_q + 2'd1 : idx_q;

      // Display uses the post-push history so a same-edge push shows at once.
      an_d  = ~(4'b0001 << idx_d);
      seg_d = valid_d[idx_d] ? hex_to_seg(hist_d[idx_d]) : SEG_BLANK;
      dp_d  = !((idx_d == 2'd0) && valid_d[0]);
   end

   // History, scan and output registers.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         hist_q      <= '0;
         valid_q     <= '0;
         refresh_q   <= '0;
         idx_q       <= '0;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
         an_q        <= 4'hF;
         new_value_q <= 1'b0;
      end else begin
         hist_q      <= hist_d;
         valid_q     <= valid_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
         new_value_q <= push;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign new_value = new_value_q;

endmodule
